// File: rtl/ace_mem_pkg.sv
// Shared memory-subsystem definitions: RAM geometry defaults and the
// owner tag carried through the arbiter's read-return pipeline.
package ace_mem_pkg;

  localparam int RAM_AW = 15;
  localparam int RAM_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating counter of consecutive refused CPU cycles; o_full forces a CPU slot.
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_full
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_full;

  assign w_full = (r_cnt == CW'(LIMIT));
  assign o_full = w_full;

  // Clear has priority so a CPU handshake on a forced cycle releases the force.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates one single-port synchronous RAM between the Z80 CPU and video fetch,
// video first with a starvation guard, returning reads 2 cycles after handshake.
module ram_arbiter
  import ace_mem_pkg::*;
#(
  parameter int AW           = RAM_AW,
  parameter int DW           = RAM_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_gnt,
  output logic          cpu_wait,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_dout,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_dout,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic          w_force;
  logic          w_cpu_gnt;
  logic          w_vid_gnt;
  logic          w_cpu_hs;
  logic          w_vid_hs;
  owner_e        w_own;

  logic          r_ce;
  logic          r_we;
  logic [AW-1:0] r_a;
  logic [DW-1:0] r_din;
  owner_e        r_own1;
  owner_e        r_own2;

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (cpu_req & ~w_cpu_gnt),
    .i_clr  (~cpu_req | w_cpu_gnt),
    .o_full (w_force)
  );

  // Grants are gated by rst_n so nothing can be granted while reset is held.
  always_comb begin
    w_vid_gnt = rst_n & vid_req & ~w_force;
    w_cpu_gnt = rst_n & cpu_req & (~vid_req | w_force);
    w_cpu_hs  = cpu_req & w_cpu_gnt;
    w_vid_hs  = vid_req & w_vid_gnt;
    w_own     = OWN_NONE;
    if (w_cpu_hs && !cpu_we) begin
      w_own = OWN_CPU;
    end else if (w_vid_hs) begin
      w_own = OWN_VID;
    end
  end

  // RAM drive is registered; a/din keep their last value on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce   <= 1'b0;
      r_we   <= 1'b0;
      r_a    <= '0;
      r_din  <= '0;
      r_own1 <= OWN_NONE;
      r_own2 <= OWN_NONE;
    end else begin
      r_ce   <= w_cpu_hs | w_vid_hs;
      r_we   <= w_cpu_hs & cpu_we;
      r_own1 <= w_own;
      r_own2 <= r_own1;
      if (w_cpu_hs) begin
        r_a   <= cpu_addr;
        r_din <= cpu_din;
      end else if (w_vid_hs) begin
        r_a   <= vid_addr;
        r_din <= '0;
      end
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign vid_gnt    = w_vid_gnt;
  assign cpu_wait   = cpu_req & ~w_cpu_gnt;
  assign cpu_rvalid = (r_own2 == OWN_CPU);
  assign vid_rvalid = (r_own2 == OWN_VID);
  assign cpu_dout   = ram_dout;
  assign vid_dout   = ram_dout;
  assign ram_ce     = r_ce;
  assign ram_we     = r_we;
  assign ram_a      = r_a;
  assign ram_din    = r_din;

endmodule
